sd_digit_sequencer: RTL

SD_DIGIT_SEQUENCER -- requirements
Module: sd_digit_sequencer

---
 rtl/sd_digit_sequencer_pkg.sv | 24 ++
 rtl/sd_tag_pipe.sv | 37 +++
 rtl/sd_digit_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sd_digit_sequencer_pkg.sv
// rtl/sd_digit_sequencer_pkg.sv - shared FSM state encoding and signed-digit codes
// Contents: sd_state_e (IDLE/STREAM/FLUSH/DONE), SD_POS/SD_NEG/SD_ZERO digit codes,
//           sd_encode() mapping one plus/minus bit pair onto a digit code.
package sd_digit_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } sd_state_e;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  // plus==minus (both 0 or both 1) cancels to zero.
  function automatic logic [1:0] sd_encode(input logic plus, input logic minus);
    if (plus && !minus) return SD_POS;
    if (minus && !plus) return SD_NEG;
    return SD_ZERO;
  endfunction

endpackage

// File: rtl/sd_tag_pipe.sv
// rtl/sd_tag_pipe.sv - enabled tag shift register mirroring the downstream register latency
// Ports: clk, rst (async, active-high), clr (sync clear, wins over en),
//        en (advance one stage), tag_in (tag entering stage 0), tag_out (oldest stage).
module sd_tag_pipe #(
  parameter int depth = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tag_in,
  output logic tag_out
);

  logic [depth-1:0] tags_q;
  logic [depth-1:0] tags_d;

  always_comb begin
    tags_d = tags_q;
    if (clr) begin
      tags_d = '0;
    end else if (en) begin
      tags_d = (tags_q << 1) | depth'(tag_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_q <= '0;
    end else begin
      tags_q <= tags_d;
    end
  end

  assign tag_out = tags_q[depth-1];

endmodule

// File: rtl/sd_digit_sequencer.sv
// rtl/sd_digit_sequencer.sv - streams a captured signed-digit operand MSD first
// Ports: clk, asyn_reset (async, active-high)
//        start/op_plus/op_minus: capture a new operand while ready
//        stall: freeze sequencing in STREAM/FLUSH; abort: cancel back to IDLE
//        ready, digit_select, enable, out_valid, digit_index, done: sequencing outputs
module sd_digit_sequencer
  import sd_digit_sequencer_pkg::*;
#(
  parameter int Num_bits   = 4,
  parameter int Num_digits = 8,
  parameter int Latency    = 1
) (
  input  logic                          clk,
  input  logic                          asyn_reset,
  input  logic                          start,
  input  logic [Num_digits-1:0]         op_plus,
  input  logic [Num_digits-1:0]         op_minus,
  input  logic                          stall,
  input  logic                          abort,
  output logic                          ready,
  output logic [1:0]                    digit_select,
  output logic                          enable,
  output logic                          out_valid,
  output logic [$clog2(Num_digits)-1:0] digit_index,
  output logic                          done
);

  localparam int IW = $clog2(Num_digits);
  localparam int CW = $clog2(Latency + 1);
  localparam logic [IW-1:0] LAST_INDEX = IW'(Num_digits - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(Latency - 1);

  // Num_bits only sizes the downstream datapath; it is carried so that
  // instantiations stay uniform across the digit-select blocks.
  if (Num_bits < 1) begin : g_num_bits_unused
  end

  sd_state_e             state_q, state_d;
  logic [Num_digits-1:0] plus_q, plus_d;
  logic [Num_digits-1:0] minus_q, minus_d;
  logic [IW-1:0]         index_q, index_d;
  logic [IW-1:0]         next_index;
  logic [CW-1:0]         flush_q, flush_d;
  logic [1:0]            digit_q, digit_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  tag_clr;
  logic                  tag_in;

  assign next_index = index_q - 1'b1;

  always_comb begin
    state_d = state_q;
    plus_d  = plus_q;
    minus_d = minus_q;
    index_d = index_q;
    flush_d = flush_q;
    digit_d = digit_q;
    en_d    = en_q;
    done_d  = 1'b0;
    tag_clr = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      index_d = '0;
      digit_d = SD_ZERO;
      en_d    = 1'b0;
      tag_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            plus_d  = op_plus;
            minus_d = op_minus;
            index_d = LAST_INDEX;
            // Present the MSD in the very first STREAM cycle.
            digit_d = sd_encode(op_plus[Num_digits-1], op_minus[Num_digits-1]);
            en_d    = 1'b1;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (!stall) begin
            if (index_q == '0) begin
              state_d = ST_FLUSH;
              digit_d = SD_ZERO;
              flush_d = '0;
            end else begin
              index_d = next_index;
              digit_d = sd_encode(plus_q[next_index], minus_q[next_index]);
            end
          end
        end
        ST_FLUSH: begin
          if (!stall) begin
            if (flush_q == LAST_FLUSH) begin
              state_d = ST_DONE;
              en_d    = 1'b0;
              done_d  = 1'b1;
            end else begin
              flush_d = flush_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q <= ST_IDLE;
      plus_q  <= '0;
      minus_q <= '0;
      index_q <= '0;
      flush_q <= '0;
      digit_q <= SD_ZERO;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plus_q  <= plus_d;
      minus_q <= minus_d;
      index_q <= index_d;
      flush_q <= flush_d;
      digit_q <= digit_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // en_q is only set in STREAM/FLUSH, so stall is a no-op in IDLE and DONE.
  assign enable = en_q & ~stall;
  assign tag_in = (state_q == ST_STREAM);

  sd_tag_pipe #(
    .depth(Latency)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (asyn_reset),
    .clr     (tag_clr),
    .en      (enable),
    .tag_in  (tag_in),
    .tag_out (out_valid)
  );

  assign ready        = (state_q == ST_IDLE);
  assign digit_select = digit_q;
  assign digit_index  = index_q;
  assign done         = done_q;

endmodule
